// File: rtl/warp_ibuf.sv
// Dual-issue instruction buffer between fetch and decode.
// Circular storage of DEPTH slots; up to two entries enter and two leave per cycle.
// Capacity and occupancy outputs come only from registered pointers, so neither
// stage sees a combinational path through the other.
module warp_ibuf #(
    parameter int unsigned WIDTH = 32,  // bits per instruction slot
    parameter int unsigned DEPTH = 4    // storage entries; power of two, >= 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic [1:0]       i_wcount,
    input  logic [WIDTH-1:0] i_wdata0,
    input  logic [WIDTH-1:0] i_wdata1,
    output logic [1:0]       o_wcapacity,
    output logic [1:0]       o_rcount,
    output logic [WIDTH-1:0] o_rdata0,
    output logic [WIDTH-1:0] o_rdata1,
    input  logic [1:0]       i_rconsume
);

    localparam int unsigned AW = $clog2(DEPTH);
    // One extra pointer bit tells full from empty.
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] DepthW = PW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW-1:0]    count;
    logic [PW-1:0]    free;
    logic [1:0]       wcap;
    logic [1:0]       rcnt;
    logic [1:0]       wacc;
    logic [1:0]       racc;
    logic [AW-1:0]    widx0, widx1;
    logic [AW-1:0]    ridx0, ridx1;

    // Occupancy, accepted transfer sizes and next pointers.
    always_comb begin
        count = wptr_q - rptr_q;
        free  = DepthW - count;
        wcap  = (free  >= PW'(2)) ? 2'd2 : free[1:0];
        rcnt  = (count >= PW'(2)) ? 2'd2 : count[1:0];

        // A request of 3 is not a legal encoding and moves nothing.
        wacc = 2'd0;
        if (i_wcount != 2'd3) begin
            wacc = (i_wcount < wcap) ? i_wcount : wcap;
        end
        racc = 2'd0;
        if (i_rconsume != 2'd3) begin
            racc = (i_rconsume < rcnt) ? i_rconsume : rcnt;
        end

        widx0 = wptr_q[AW-1:0];
        widx1 = wptr_q[AW-1:0] + AW'(1);
        ridx0 = rptr_q[AW-1:0];
        ridx1 = rptr_q[AW-1:0] + AW'(1);

        if (i_flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            wptr_d = wptr_q + PW'(wacc);
            rptr_d = rptr_q + PW'(racc);
        end
    end

    // Pointer registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage; cleared on reset so the read ports show zero afterwards.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (!i_flush) begin
            if (wacc != 2'd0) begin
                mem_q[widx0] <= i_wdata0;
            end
            if (wacc == 2'd2) begin
                mem_q[widx1] <= i_wdata1;
            end
        end
    end

    // Registered-state outputs; no bypass from the write port.
    always_comb begin
        o_wcapacity = wcap;
        o_rcount    = rcnt;
        o_rdata0    = mem_q[ridx0];
        o_rdata1    = mem_q[ridx1];
    end

`ifdef FORMAL
    // Occupancy bound and legal-handshake environment.
    always_comb begin
        assert (count <= DepthW);
        if (i_rst_n) begin
            assume (i_wcount <= o_wcapacity);
            assume (i_rconsume <= o_rcount);
        end
    end
`endif

endmodule

// File: tb/tb_warp_ibuf.sv
// Self-checking bench for warp_ibuf: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_warp_ibuf;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic [1:0]       wcount;
    logic [WIDTH-1:0] wdata0;
    logic [WIDTH-1:0] wdata1;
    logic [1:0]       wcapacity;
    logic [1:0]       rcount;
    logic [WIDTH-1:0] rdata0;
    logic [WIDTH-1:0] rdata1;
    logic [1:0]       rconsume;

    int n_tests = 0;
    int n_fail  = 0;

    warp_ibuf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_flush     (flush),
        .i_wcount    (wcount),
        .i_wdata0    (wdata0),
        .i_wdata1    (wdata1),
        .o_wcapacity (wcapacity),
        .o_rcount    (rcount),
        .o_rdata0    (rdata0),
        .o_rdata1    (rdata1),
        .i_rconsume  (rconsume)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: an ordered queue of stored entries.
    logic [WIDTH-1:0] model_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
        end else if (flush) begin
            model_q.delete();
        end else begin
            int sz, ra, wa;
            sz = model_q.size();
            ra = (rconsume == 2'd3) ? 0 : min2(int'(rconsume), min2(sz, 2));
            wa = (wcount == 2'd3) ? 0 : min2(int'(wcount), min2(int'(DEPTH) - sz, 2));
            for (int k = 0; k < ra; k++) void'(model_q.pop_front());
            if (wa >= 1) model_q.push_back(wdata0);
            if (wa == 2) model_q.push_back(wdata1);
        end
    end

    // Compare process: on every falling edge the outputs must match the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_rcount", 32'(rcount), 32'd0);
            check("rst_wcap", 32'(wcapacity), 32'd2);
            check("rst_rdata0", rdata0, 32'd0);
            check("rst_rdata1", rdata1, 32'd0);
        end else begin
            int sz;
            sz = model_q.size();
            check("mdl_rcount", 32'(rcount), 32'(min2(sz, 2)));
            check("mdl_wcap", 32'(wcapacity), 32'(min2(int'(DEPTH) - sz, 2)));
            if (sz >= 1) check("mdl_rdata0", rdata0, model_q[0]);
            if (sz >= 2) check("mdl_rdata1", rdata1, model_q[1]);
        end
    end

    // Drive one cycle of inputs, then settle just after the edge.
    task automatic cyc(input int wc, input int d0, input int d1, input int rc, input bit fl);
        wcount   = 2'(wc);
        wdata0   = 32'(d0);
        wdata1   = 32'(d1);
        rconsume = 2'(rc);
        flush    = fl;
        @(posedge clk);
        #2;
    endtask

    int wc_tab [16] = '{2, 2, 2, 1, 3, 0, 1, 2, 2, 0, 0, 3, 1, 1, 2, 0};
    int rc_tab [16] = '{0, 0, 1, 0, 2, 3, 0, 0, 1, 2, 2, 0, 3, 1, 0, 2};

    initial begin
        logic [WIDTH-1:0] seen[$];
        rst_n    = 1'b0;
        flush    = 1'b0;
        wcount   = 2'd0;
        wdata0   = '0;
        wdata1   = '0;
        rconsume = 2'd0;

        // Reset values.
        #12;
        check("reset_rcount", 32'(rcount), 32'd0);
        check("reset_wcap", 32'(wcapacity), 32'd2);
        check("reset_rdata0", rdata0, 32'd0);
        #10;
        rst_n = 1'b1;

        // Two entries, first edge after release.
        cyc(2, 'hA, 'hB, 0, 0);
        check("w2_rcount", 32'(rcount), 32'd2);
        check("w2_rdata0", rdata0, 32'hA);
        check("w2_rdata1", rdata1, 32'hB);
        check("w2_wcap", 32'(wcapacity), 32'd2);

        // Fill to DEPTH, overflow dropped, then consume one.
        cyc(2, 'hC, 'hD, 0, 0);
        check("full_wcap", 32'(wcapacity), 32'd0);
        cyc(2, 'hE, 'hF, 0, 0);
        check("drop_rdata0", rdata0, 32'hA);
        check("drop_wcap", 32'(wcapacity), 32'd0);
        cyc(0, 0, 0, 1, 0);
        check("c1_wcap", 32'(wcapacity), 32'd1);
        check("c1_rdata0", rdata0, 32'hB);
        check("c1_rdata1", rdata1, 32'hC);
        cyc(0, 0, 0, 2, 0);
        cyc(0, 0, 0, 2, 0);
        check("drain_rcount", 32'(rcount), 32'd0);
        cyc(0, 0, 0, 2, 0);
        check("empty_read_ignored", 32'(wcapacity), 32'd2);

        // Streaming 1..10 with simultaneous read and write.
        for (int k = 0; k < 6; k++) begin
            if (rcount == 2'd2) begin
                seen.push_back(rdata0);
                seen.push_back(rdata1);
            end
            check("stream_wcap", 32'(wcapacity), 32'd2);
            if (k < 5) cyc(2, 2 * k + 1, 2 * k + 2, 2, 0);
            else       cyc(0, 0, 0, 2, 0);
        end
        check("stream_len", 32'(seen.size()), 32'd10);
        for (int k = 0; k < 10 && k < seen.size(); k++) begin
            check("stream_order", seen[k], 32'(k + 1));
        end
        check("stream_end_rcount", 32'(rcount), 32'd0);

        // Flush overrides write and read in the same cycle.
        cyc(2, 'h31, 'h32, 0, 0);
        cyc(1, 'h33, 0, 0, 0);
        check("three_wcap", 32'(wcapacity), 32'd1);
        cyc(2, 'h34, 'h35, 1, 1);
        check("flush_rcount", 32'(rcount), 32'd0);
        check("flush_wcap", 32'(wcapacity), 32'd2);

        // Consume-and-refill.
        cyc(1, 'h5, 0, 0, 0);
        check("one_rdata0", rdata0, 32'h5);
        cyc(1, 'h6, 0, 1, 0);
        check("swap_rcount", 32'(rcount), 32'd1);
        check("swap_rdata0", rdata0, 32'h6);

        // Encoding 3 moves nothing.
        cyc(3, 'h7, 'h8, 3, 0);
        check("enc3_rcount", 32'(rcount), 32'd1);
        check("enc3_rdata0", rdata0, 32'h6);

        // Asynchronous reset mid-stream with three stored.
        cyc(2, 'h41, 'h42, 0, 0);
        check("pre_rst_wcap", 32'(wcapacity), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_rcount", 32'(rcount), 32'd0);
        check("arst_wcap", 32'(wcapacity), 32'd2);
        check("arst_rdata0", rdata0, 32'd0);
        check("arst_rdata1", rdata1, 32'd0);
        wcount   = 2'd0;
        rconsume = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 'h77, 0, 0, 0);
        check("post_rst_rcount", 32'(rcount), 32'd1);
        check("post_rst_rdata0", rdata0, 32'h77);
        check("post_rst_rdata1", rdata1, 32'd0);

        // Mixed traffic checked by the model alone.
        for (int k = 0; k < 16; k++) begin
            cyc(wc_tab[k], 'h100 + 2 * k, 'h101 + 2 * k, rc_tab[k], k == 9);
        end
        cyc(0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/warp_ibuf.md
WARP_IBUF -- requirements
Module: warp_ibuf

Interface
REQ-001 Parameters SHALL be declared one per line as name, default, meaning:
  WIDTH   32   bits per instruction slot
  DEPTH   4    number of storage entries; power of two, at least 2
REQ-002 Ports SHALL be declared one per line as name, direction, width, meaning:
  i_clk        in   1      clock; all state updates on its rising edge
  i_rst_n      in   1      reset, asynchronous, active-low
  i_flush      in   1      synchronous discard of all contents (redirect)
  i_wcount     in   2      entries offered this cycle by upstream stage: 0, 1 or 2
  i_wdata0     in   WIDTH  older offered entry
  i_wdata1     in   WIDTH  younger offered entry
  o_wcapacity  out  2      free slots available to upstream, min(DEPTH-count, 2)
  o_rcount     out  2      entries presented downstream, min(count, 2)
  o_rdata0     out  WIDTH  oldest stored entry
  o_rdata1     out  WIDTH  second-oldest stored entry
  i_rconsume   in   2      entries taken by downstream this cycle: 0, 1 or 2
REQ-003 Clock is i_clk; reset is i_rst_n, asynchronous, active-low.

Function
REQ-004 Storage SHALL be a circular buffer of DEPTH entries with read and write pointers of log2(DEPTH)+1 bits; count = wptr - rptr, modulo 2^(log2(DEPTH)+1).
REQ-005 Pointer and entry indexing SHALL wrap modulo DEPTH; full SHALL be distinguished from empty by the pointer MSB.
REQ-006 o_wcapacity and o_rcount SHALL be derived only from registered count; neither SHALL combinationally depend on any input.
REQ-007 Accepted writes SHALL be wa = min(i_wcount, o_wcapacity); i_wdata0 goes to mem[wptr], i_wdata1 to mem[wptr+1] only when wa = 2; wptr advances by wa.
REQ-008 Accepted reads SHALL be ra = min(i_rconsume, o_rcount); rptr advances by ra.
REQ-009 i_wcount = 3 and i_rconsume = 3 SHALL be treated as 0.
REQ-010 o_rdata0 = mem[rptr] and o_rdata1 = mem[rptr+1]; an entry written in cycle N SHALL first be visible at the outputs in cycle N+1; there is no write-to-read bypass.
REQ-011 Simultaneous read and write SHALL both take effect in the same cycle; freed slots SHALL NOT raise o_wcapacity until the next cycle.
REQ-012 When count = DEPTH, o_wcapacity SHALL be 0 and all writes dropped; when count = 0, o_rcount SHALL be 0 and all reads ignored.
REQ-013 Entry order SHALL be preserved: output order equals accepted input order, slot 0 before slot 1.
REQ-014 i_flush SHALL set wptr = rptr = 0 at the next edge, and SHALL override every write and read in the same cycle.
REQ-015 o_rdata0/o_rdata1 contents are undefined whenever the corresponding slot index is >= o_rcount, except directly after reset (REQ-017).
REQ-016 Under formal, the block SHALL assert count <= DEPTH, and SHALL assume i_wcount <= o_wcapacity and i_rconsume <= o_rcount.

Reset
REQ-017 Asserting i_rst_n low SHALL asynchronously clear both pointers and all storage entries to 0, at any point in operation.
REQ-018 While in reset, o_rcount SHALL be 0, o_wcapacity SHALL be 2, and o_rdata0 and o_rdata1 SHALL be 0.
REQ-019 Deassertion SHALL be synchronous to i_clk; the first write SHALL be accepted on the first rising edge after release.

Verification
REQ-020 Reset, then write 2 entries (0xA, 0xB) with i_rconsume = 0 -> next cycle o_rcount = 2, o_rdata0 = 0xA, o_rdata1 = 0xB, o_wcapacity = 2.
REQ-021 DEPTH = 4; write 2 entries, then 2 more -> o_wcapacity = 0; a further i_wcount = 2 is dropped; then consume 1 -> next cycle o_wcapacity = 1, o_rdata0 = the 2nd entry.
REQ-022 Wrap-around: stream 10 entries 1..10 with i_wcount = 2 and i_rconsume = 2 every cycle -> output sequence is exactly 1..10, count never exceeds 2, and pointers wrap cleanly.
REQ-023 Buffer holding 3 entries; i_flush = 1 with i_wcount = 2 and i_rconsume = 1 in the same cycle -> next cycle o_rcount = 0 and o_wcapacity = 2.
REQ-024 Write 1 entry 0x5 and consume 1 in the following cycle, with i_wcount = 1 (0x6) in that same cycle -> next cycle o_rcount = 1 and o_rdata0 = 0x6.
REQ-025 Pull i_rst_n low mid-stream while count = 3 -> outputs immediately show o_rcount = 0, o_wcapacity = 2 and o_rdata0 = o_rdata1 = 0.
